// File: rtl/pipe_stage_reg_if.sv
// Bundle of stage-control, payload-in and registered payload-out signals
// for one inter-stage pipeline register.
interface pipe_stage_reg_if #(
  parameter int unsigned DW   = 32,
  parameter int unsigned NCH  = 4,
  parameter int unsigned EXCW = 5,
  parameter int unsigned CNTW = 8
);
  logic              en;
  logic              bubble;
  logic              flush;
  logic              valid_in;
  logic [DW-1:0]     instr_in;
  logic [DW-1:0]     pc_in;
  logic              bd_in;
  logic [EXCW-1:0]   exc_in;
  logic [EXCW-1:0]   stage_exc;
  logic [NCH*DW-1:0] data_in;

  logic              valid_out;
  logic [DW-1:0]     instr_out;
  logic [DW-1:0]     pc_out;
  logic              bd_out;
  logic [EXCW-1:0]   exc_out;
  logic [NCH*DW-1:0] data_out;
  logic [CNTW-1:0]   hold_cnt;

  modport master (
    output en, bubble, flush, valid_in, instr_in, pc_in, bd_in,
           exc_in, stage_exc, data_in,
    input  valid_out, instr_out, pc_out, bd_out, exc_out, data_out, hold_cnt
  );

  modport slave (
    input  en, bubble, flush, valid_in, instr_in, pc_in, bd_in,
           exc_in, stage_exc, data_in,
    output valid_out, instr_out, pc_out, bd_out, exc_out, data_out, hold_cnt
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: hold, bubble, flush and first-exception-wins
// merging of the exception code; all outputs come straight from flops.
module pipe_stage_reg #(
  parameter int unsigned    DW       = 32,
  parameter int unsigned    NCH      = 4,
  parameter int unsigned    EXCW     = 5,
  parameter logic [DW-1:0]  PC_RESET = 32'h0000_3000,
  parameter int unsigned    CNTW     = 8
) (
  input logic             clk,
  input logic             rst,
  pipe_stage_reg_if.slave p
);
  typedef enum logic [1:0] {
    ACT_CLEAR,
    ACT_BUBBLE,
    ACT_HOLD,
    ACT_LOAD
  } act_e;

  act_e              act;
  logic              valid_q, valid_d;
  logic [DW-1:0]     instr_q, instr_d;
  logic [DW-1:0]     pc_q, pc_d;
  logic              bd_q, bd_d;
  logic [EXCW-1:0]   exc_q, exc_d;
  logic [NCH*DW-1:0] data_q, data_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [EXCW-1:0]   exc_merged;

  always_comb begin
    if (rst || p.flush)   act = ACT_CLEAR;
    else if (p.bubble)    act = ACT_BUBBLE;
    else if (!p.en)       act = ACT_HOLD;
    else                  act = ACT_LOAD;
  end

  // Earliest exception wins; a stage's own detection only counts for a real instruction.
  always_comb begin
    if (p.exc_in != '0)   exc_merged = p.exc_in;
    else if (p.valid_in)  exc_merged = p.stage_exc;
    else                  exc_merged = '0;
  end

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    bd_d    = bd_q;
    exc_d   = exc_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    unique case (act)
      ACT_CLEAR: begin
        valid_d = 1'b0;
        instr_d = '0;
        pc_d    = PC_RESET;
        bd_d    = 1'b0;
        exc_d   = '0;
        data_d  = '0;
        cnt_d   = '0;
      end
      ACT_BUBBLE: begin
        // PC and delay-slot flag survive so EPC is right if an interrupt lands here.
        valid_d = 1'b0;
        instr_d = '0;
        pc_d    = p.pc_in;
        bd_d    = p.bd_in;
        exc_d   = '0;
        data_d  = '0;
        cnt_d   = '0;
      end
      ACT_HOLD: begin
        if (cnt_q != '1) cnt_d = cnt_q + CNTW'(1);
      end
      ACT_LOAD: begin
        valid_d = p.valid_in;
        instr_d = p.instr_in;
        pc_d    = p.pc_in;
        bd_d    = p.bd_in;
        exc_d   = exc_merged;
        data_d  = p.data_in;
        cnt_d   = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    valid_q <= valid_d;
    instr_q <= instr_d;
    pc_q    <= pc_d;
    bd_q    <= bd_d;
    exc_q   <= exc_d;
    data_q  <= data_d;
    cnt_q   <= cnt_d;
  end

  assign p.valid_out = valid_q;
  assign p.instr_out = instr_q;
  assign p.pc_out    = pc_q;
  assign p.bd_out    = bd_q;
  assign p.exc_out   = exc_q;
  assign p.data_out  = data_q;
  assign p.hold_cnt  = cnt_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: two instances (CNTW=8 and CNTW=2) share stimulus and
// are compared every cycle against a priority-rule model plus directed literals.
module tb_pipe_stage_reg;
  localparam int unsigned DW   = 32;
  localparam int unsigned NCH  = 4;
  localparam int unsigned EXCW = 5;
  localparam logic [31:0] PCR  = 32'h0000_3000;

  logic clk = 1'b0;
  logic rst;
  logic en, bubble, flush, valid_in, bd_in;
  logic [DW-1:0] instr_in, pc_in;
  logic [EXCW-1:0] exc_in, stage_exc;
  logic [NCH*DW-1:0] data_in;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DW(DW), .NCH(NCH), .EXCW(EXCW), .CNTW(8)) ifa ();
  pipe_stage_reg_if #(.DW(DW), .NCH(NCH), .EXCW(EXCW), .CNTW(2)) ifb ();

  assign ifa.en = en;            assign ifb.en = en;
  assign ifa.bubble = bubble;    assign ifb.bubble = bubble;
  assign ifa.flush = flush;      assign ifb.flush = flush;
  assign ifa.valid_in = valid_in; assign ifb.valid_in = valid_in;
  assign ifa.instr_in = instr_in; assign ifb.instr_in = instr_in;
  assign ifa.pc_in = pc_in;      assign ifb.pc_in = pc_in;
  assign ifa.bd_in = bd_in;      assign ifb.bd_in = bd_in;
  assign ifa.exc_in = exc_in;    assign ifb.exc_in = exc_in;
  assign ifa.stage_exc = stage_exc; assign ifb.stage_exc = stage_exc;
  assign ifa.data_in = data_in;  assign ifb.data_in = data_in;

  pipe_stage_reg #(.DW(DW), .NCH(NCH), .EXCW(EXCW), .PC_RESET(PCR), .CNTW(8)) dut_a (
    .clk(clk), .rst(rst), .p(ifa)
  );
  pipe_stage_reg #(.DW(DW), .NCH(NCH), .EXCW(EXCW), .PC_RESET(PCR), .CNTW(2)) dut_b (
    .clk(clk), .rst(rst), .p(ifb)
  );

  // Reference state, advanced at each rising edge from the action-priority rules.
  logic              m_ok = 1'b0;
  logic              m_valid, m_bd;
  logic [31:0]       m_instr, m_pc;
  logic [EXCW-1:0]   m_exc;
  logic [NCH*DW-1:0] m_data;
  int                m_cnt_a, m_cnt_b;

  always @(posedge clk) begin
    if (rst || flush) begin
      m_ok = 1'b1;
      {m_valid, m_bd, m_instr, m_exc, m_data} = '0;
      m_pc = PCR; m_cnt_a = 0; m_cnt_b = 0;
    end else if (bubble) begin
      {m_valid, m_instr, m_exc, m_data} = '0;
      m_pc = pc_in; m_bd = bd_in; m_cnt_a = 0; m_cnt_b = 0;
    end else if (!en) begin
      m_cnt_a = (m_cnt_a < 255) ? m_cnt_a + 1 : 255;
      m_cnt_b = (m_cnt_b < 3) ? m_cnt_b + 1 : 3;
    end else begin
      m_valid = valid_in; m_instr = instr_in; m_pc = pc_in; m_bd = bd_in;
      m_data = data_in; m_cnt_a = 0; m_cnt_b = 0;
      m_exc = (exc_in != 0) ? exc_in : (valid_in ? stage_exc : '0);
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_ok) begin
      chk("valid_out", 128'(ifa.valid_out), 128'(m_valid));
      chk("instr_out", 128'(ifa.instr_out), 128'(m_instr));
      chk("pc_out",    128'(ifa.pc_out),    128'(m_pc));
      chk("bd_out",    128'(ifa.bd_out),    128'(m_bd));
      chk("exc_out",   128'(ifa.exc_out),   128'(m_exc));
      chk("data_out",  ifa.data_out,        m_data);
      chk("hold_cnt_a", 128'(ifa.hold_cnt), 128'(m_cnt_a));
      chk("hold_cnt_b", 128'(ifb.hold_cnt), 128'(m_cnt_b));
      chk("b_vs_a_payload", {ifb.valid_out, ifb.instr_out, ifb.pc_out, ifb.exc_out},
          {m_valid, m_instr, m_pc, m_exc});
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    {en, bubble, flush, valid_in, bd_in} = '0;
    instr_in = '0; pc_in = '0; exc_in = '0; stage_exc = '0; data_in = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    step(); step();
    chk("reset_pc", 128'(ifa.pc_out), 128'(32'h3000));
    chk("reset_instr", 128'(ifa.instr_out), 128'd0);
    chk("reset_valid", 128'(ifa.valid_out), 128'd0);
    chk("reset_hold", 128'(ifa.hold_cnt), 128'd0);

    rst = 1'b0; en = 1'b1; instr_in = 32'h2408_0005; pc_in = 32'h3004; valid_in = 1'b1;
    step();
    chk("load_instr", 128'(ifa.instr_out), 128'(32'h2408_0005));
    chk("load_pc", 128'(ifa.pc_out), 128'(32'h3004));
    chk("load_valid", 128'(ifa.valid_out), 128'd1);

    instr_in = 32'h8C09_0000; pc_in = 32'h3008;
    step();
    for (int i = 1; i <= 3; i++) begin
      en = 1'b0; instr_in = 32'h1111_0000 + 32'(i); pc_in = 32'h4000 + 32'(4 * i);
      step();
      chk("hold_instr", 128'(ifa.instr_out), 128'(32'h8C09_0000));
      chk("hold_pc", 128'(ifa.pc_out), 128'(32'h3008));
      chk("hold_cnt_seq", 128'(ifa.hold_cnt), 128'(i));
    end
    en = 1'b1; instr_in = 32'h0000_1234; pc_in = 32'h300C;
    step();
    chk("release_instr", 128'(ifa.instr_out), 128'(32'h0000_1234));
    chk("release_hold", 128'(ifa.hold_cnt), 128'd0);

    en = 1'b0; bubble = 1'b1; pc_in = 32'h3010; bd_in = 1'b1; exc_in = 5'd3;
    step();
    chk("bubble_instr", 128'(ifa.instr_out), 128'd0);
    chk("bubble_valid", 128'(ifa.valid_out), 128'd0);
    chk("bubble_exc", 128'(ifa.exc_out), 128'd0);
    chk("bubble_pc", 128'(ifa.pc_out), 128'(32'h3010));
    chk("bubble_bd", 128'(ifa.bd_out), 128'd1);

    en = 1'b1; flush = 1'b1; bubble = 1'b1;
    step();
    chk("flush_pc", 128'(ifa.pc_out), 128'(32'h3000));
    chk("flush_bd", 128'(ifa.bd_out), 128'd0);
    chk("flush_valid", 128'(ifa.valid_out), 128'd0);

    idle_inputs();
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("sat_cnt_b", 128'(ifb.hold_cnt), 128'((i < 3) ? i : 3));
      chk("cnt_a", 128'(ifa.hold_cnt), 128'(i));
    end
    rst = 1'b1;
    step();
    chk("rst_mid_hold", 128'(ifa.hold_cnt), 128'd0);
    rst = 1'b0;

    en = 1'b1; valid_in = 1'b1; exc_in = 5'd4; stage_exc = 5'd12;
    step();
    chk("exc_keep_earlier", 128'(ifa.exc_out), 128'd4);
    exc_in = 5'd0;
    step();
    chk("exc_take_stage", 128'(ifa.exc_out), 128'd12);
    valid_in = 1'b0;
    step();
    chk("exc_invalid", 128'(ifa.exc_out), 128'd0);

    data_in = {32'hD, 32'hC, 32'hB, 32'hA};
    step();
    chk("chan0", 128'(ifa.data_out[0 +: 32]), 128'(32'hA));
    chk("chan3", 128'(ifa.data_out[96 +: 32]), 128'(32'hD));

    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 63) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      bubble    = ($urandom_range(0, 7) == 0);
      en        = ($urandom_range(0, 3) != 0) || (n % 200 > 190 ? 1'b0 : 1'b0);
      if (n % 300 < 8) begin en = 1'b0; bubble = 1'b0; flush = 1'b0; rst = 1'b0; end
      valid_in  = 1'($urandom);
      bd_in     = 1'($urandom);
      instr_in  = $urandom;
      pc_in     = $urandom;
      exc_in    = $urandom_range(0, 1) ? EXCW'($urandom_range(1, 31)) : '0;
      stage_exc = EXCW'($urandom_range(0, 31));
      data_in   = {$urandom, $urandom, $urandom, $urandom};
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the exception-capable five-stage MIPS core. It replaces the per-stage instruction-only registers with one block, instantiated at D/E, E/M and M/W. Each instance carries the instruction, PC, branch-delay flag, valid bit, exception code and NCH generic data channels. It supports hold (stall), bubble insertion, global flush and first-exception-wins code merging.

## Interface
- DW, 32, width of instruction, PC and each data channel
- NCH, 4, number of generic data channels, 1..8
- EXCW, 5, exception code width; 0 means "no exception"
- PC_RESET, 32'h0000_3000, PC value loaded on reset and flush
- CNTW, 8, width of the hold-cycle counter

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- en  in  1  advance enable; 0 = hold current contents (stall)
- bubble  in  1  insert a NOP bubble in place of the incoming instruction
- flush  in  1  exception/eret flush; clears the stage entirely
- valid_in  in  1  incoming slot holds a real instruction
- instr_in  in  DW  incoming instruction word
- pc_in  in  DW  incoming PC
- bd_in  in  1  incoming instruction sits in a branch delay slot
- exc_in  in  EXCW  exception code carried from earlier stages
- stage_exc  in  EXCW  exception detected by the upstream stage's logic
- data_in  in  NCH*DW  packed channels; channel k = bits [k*DW +: DW]
- valid_out, instr_out, pc_out, bd_out, exc_out, data_out  out  same widths  registered copies
- hold_cnt  out  CNTW  consecutive cycles held, saturating

## Operation
- One action per cycle, in strict priority: rst > flush > bubble > hold (en=0) > load.
- rst or flush:
  - instr_out=0, valid_out=0, bd_out=0, exc_out=0, data_out=0, hold_cnt=0.
  - pc_out=PC_RESET.
- bubble (en ignored):
  - instr_out=0, valid_out=0, exc_out=0, data_out=0, hold_cnt=0.
  - pc_out=pc_in and bd_out=bd_in, so that EPC stays correct for an interrupt taken on a bubble.
- hold (en=0, no flush or bubble):
  - All payload registers keep their value.
  - hold_cnt increments, saturating at 2^CNTW-1.
- load (en=1):
  - instr_out=instr_in, pc_out=pc_in, bd_out=bd_in, valid_out=valid_in, data_out=data_in, hold_cnt=0.
  - Exception merge:
    - If exc_in≠0, then exc_out=exc_in (the earliest exception is preserved).
    - Else if valid_in=1, then exc_out=stage_exc.
    - Else exc_out=0.
  - When valid_in=0 the remaining fields load as given. Downstream units gate on valid_out.
- No combinational path from any input to any output.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- Reset values:
  - valid_out=0, instr_out=0, pc_out=PC_RESET, bd_out=0, exc_out=0, data_out=0, hold_cnt=0.
- flush and bubble asserted together: flush wins, and pc_out=PC_RESET.
- bubble with en=0: the bubble is inserted. This is the normal load-use stall at D/E, where D holds and E takes a bubble.
- rst asserted mid-hold: the next edge clears everything, including hold_cnt.
- hold_cnt wrap: it saturates and never rolls over to 0 while holding.
- Leaving hold with en=1: the load occurs on that edge and hold_cnt becomes 0 in the same cycle.

## Test plan
- Reset, then load: rst for 2 cycles, then en=1, instr_in=32'h2408_0005, pc_in=32'h3004, valid_in=1 → the cycle after reset shows pc_out=32'h3000, instr_out=0; the next edge gives instr_out=32'h2408_0005, pc_out=32'h3004, valid_out=1.
- Hold: load instr_in=32'h8C09_0000, then en=0 for 3 cycles with different inputs → outputs unchanged; hold_cnt=1,2,3; then en=1 → new value loaded and hold_cnt=0.
- Bubble during stall: en=0, bubble=1, pc_in=32'h3010, bd_in=1 → instr_out=0, valid_out=0, exc_out=0, pc_out=32'h3010, bd_out=1.
- Flush beats bubble: flush=1, bubble=1, en=1 → pc_out=32'h3000, all other outputs 0. Asserting rst during a 5-cycle hold → hold_cnt=0 on the next edge.
- Exception merge:
  - exc_in=4, stage_exc=12, valid_in=1 → exc_out=4.
  - exc_in=0, stage_exc=12, valid_in=1 → exc_out=12.
  - exc_in=0, stage_exc=12, valid_in=0 → exc_out=0.
- Channels and saturation: NCH=4, data_in={32'hD,32'hC,32'hB,32'hA} → channel 0 outputs 32'hA and channel 3 outputs 32'hD. With CNTW=2, holding 6 cycles → hold_cnt sequence 1,2,3,3,3,3.
